// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud timing constants
// common to the receiver and the future transmitter.
package uart_pkg;

  localparam int unsigned CLK_HZ               = 32_256_000;
  localparam int unsigned BAUD                 = 115_200;
  localparam int unsigned CLKS_PER_BIT_DEFAULT = CLK_HZ / BAUD;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Double-flop synchroniser for asynchronous inputs. The reset value is a
// parameter so idle-high lines come out of reset without a false edge.
module sync_2ff #(
  parameter int unsigned         WIDTH     = 1,
  parameter logic [WIDTH-1:0]    RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 3-sample majority voting, start-glitch rejection,
// a one-entry valid/ready output register and framing/overrun error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int unsigned H  = CLKS_PER_BIT / 2;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] SMP_0    = CW'(H - 1);
  localparam logic [CW-1:0] SMP_1    = CW'(H);
  localparam logic [CW-1:0] SMP_DEC  = CW'(H + 1);
  localparam logic [BW-1:0] IDX_LAST = BW'(DATA_BITS - 1);

  logic                 rx_s;
  logic                 rx_d;
  uart_state_e          state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [1:0]           smp;
  logic [DATA_BITS-1:0] shreg;
  logic                 maj;
  logic                 at_dec;
  logic                 cnt_wrap;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx_i),
    .q     (rx_s)
  );

  // Third sample is the live synchronised line on the decision cycle.
  always_comb begin
    maj      = (smp[0] & smp[1]) | ((smp[0] | smp[1]) & rx_s);
    at_dec   = (cnt == SMP_DEC);
    cnt_wrap = (cnt == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_d        <= 1'b1;
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      smp         <= '1;
      shreg       <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      rx_d        <= rx_s;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;

      if (valid_o && ready_i) valid_o <= 1'b0;
      if (cnt == SMP_0) smp[0] <= rx_s;
      if (cnt == SMP_1) smp[1] <= rx_s;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (rx_d && !rx_s) state <= START;
        end
        START: begin
          cnt <= cnt_wrap ? '0 : cnt + 1'b1;
          if (at_dec && maj) begin
            state <= IDLE;
          end else if (cnt_wrap) begin
            state   <= DATA;
            bit_idx <= '0;
          end
        end
        DATA: begin
          cnt <= cnt_wrap ? '0 : cnt + 1'b1;
          if (at_dec) shreg <= {maj, shreg[DATA_BITS-1:1]};
          if (cnt_wrap) begin
            if (bit_idx == IDX_LAST) state <= STOP;
            else                     bit_idx <= bit_idx + 1'b1;
          end
        end
        STOP: begin
          cnt <= cnt + 1'b1;
          // Decide mid stop bit so the next start edge can arrive early.
          if (at_dec) begin
            if (maj) begin
              if (!valid_o || ready_i) begin
                data_o  <= shreg;
                valid_o <= 1'b1;
              end else begin
                overrun_o <= 1'b1;
              end
              state <= IDLE;
            end else begin
              frame_err_o <= 1'b1;
              state       <= BREAK;
            end
          end
        end
        BREAK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of frames, hand-written corner
// sequences and random bytes compared against an in-order byte model.
module tb_uart_rx;

  localparam int C       = 280;
  localparam int LAT     = 2664;
  localparam int LAT_TOL = 2;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       rx_i    = 1'b1;
  logic       ready_i = 1'b1;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       overrun_o;

  uart_rx #(
    .CLKS_PER_BIT (C),
    .DATA_BITS    (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_i        (rx_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] got_q[$];
  int   fe_cnt    = 0;
  int   ov_cnt    = 0;
  int   vhi_cnt   = 0;
  int   vrise_cyc = -1;
  logic vprev     = 1'b0;

  always @(negedge clk) begin
    if (valid_o && ready_i) got_q.push_back(data_o);
    if (valid_o) vhi_cnt++;
    if (valid_o && !vprev) vrise_cyc = cyc;
    vprev = valid_o;
    if (frame_err_o) fe_cnt++;
    if (overrun_o) ov_cnt++;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int start_cyc;

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic check_rng(input string nm, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int stop_len, input bit stop_hi);
    start_cyc = cyc;
    rx_i = 1'b0;
    step(C);
    for (int i = 0; i < 8; i++) begin
      rx_i = d[i];
      step(C);
    end
    rx_i = stop_hi;
    step(stop_len);
    rx_i = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    int         stop_len;
    bit         stop_hi;
    int         idle_after;
    int         exp_bytes;
    int         exp_fe;
  } vec_t;

  vec_t vecs[6];

  logic [7:0] exp_q[$];

  initial begin
    int fe0, ov0, vh0, lat;
    logic [7:0] rb;

    vecs[0] = '{8'hA5, C,    1'b1, 300,  1, 0};
    vecs[1] = '{8'h00, 150,  1'b1, 0,    1, 0};
    vecs[2] = '{8'hFF, C,    1'b1, 300,  1, 0};
    vecs[3] = '{8'h55, 3000, 1'b0, 1000, 0, 1};
    vecs[4] = '{8'h12, C,    1'b1, 300,  1, 0};
    vecs[5] = '{8'h81, 200,  1'b1, 300,  1, 0};

    // Reset values
    step(3);
    check("rst_valid", int'(valid_o), 0);
    check("rst_data", int'(data_o), 0);
    check("rst_ferr", int'(frame_err_o), 0);
    check("rst_ovr", int'(overrun_o), 0);
    rst_n = 1'b1;

    // Idle line after release
    step(5000);
    check("idle_valid_cnt", vhi_cnt, 0);
    check("idle_ferr_cnt", fe_cnt, 0);
    check("idle_ovr_cnt", ov_cnt, 0);
    check("idle_data", int'(data_o), 0);

    // Table-driven frames, ready_i held high
    ready_i = 1'b1;
    foreach (vecs[k]) begin
      got_q.delete();
      fe0 = fe_cnt; ov0 = ov_cnt; vh0 = vhi_cnt; vrise_cyc = -1;
      send_frame(vecs[k].data, vecs[k].stop_len, vecs[k].stop_hi);
      step(vecs[k].idle_after);
      check($sformatf("vec%0d_nbytes", k), got_q.size(), vecs[k].exp_bytes);
      if (vecs[k].exp_bytes == 1 && got_q.size() == 1) begin
        rb = got_q[0];
        check($sformatf("vec%0d_data", k), int'(rb), int'(vecs[k].data));
        lat = vrise_cyc - start_cyc - 1;
        check_rng($sformatf("vec%0d_latency", k), lat, LAT - LAT_TOL, LAT + LAT_TOL);
      end
      check($sformatf("vec%0d_valid_cycles", k), vhi_cnt - vh0, vecs[k].exp_bytes);
      check($sformatf("vec%0d_ferr", k), fe_cnt - fe0, vecs[k].exp_fe);
      check($sformatf("vec%0d_ovr", k), ov_cnt - ov0, 0);
    end

    // Start-bit glitch followed by a real frame
    got_q.delete();
    fe0 = fe_cnt;
    rx_i = 1'b0;
    step(100);
    rx_i = 1'b1;
    step(600);
    check("glitch_nbytes", got_q.size(), 0);
    check("glitch_ferr", fe_cnt - fe0, 0);
    send_frame(8'h3C, C, 1'b1);
    step(300);
    check("glitch_next_nbytes", got_q.size(), 1);
    if (got_q.size() == 1) begin
      rb = got_q[0];
      check("glitch_next_data", int'(rb), 8'h3C);
    end

    // Overrun with consumer stalled
    got_q.delete();
    fe0 = fe_cnt; ov0 = ov_cnt;
    ready_i = 1'b0;
    send_frame(8'h11, C, 1'b1);
    step(200);
    check("ovr_first_valid", int'(valid_o), 1);
    send_frame(8'h22, C, 1'b1);
    step(200);
    check("ovr_pulses", ov_cnt - ov0, 1);
    check("ovr_held_data", int'(data_o), 8'h11);
    check("ovr_held_valid", int'(valid_o), 1);
    check("ovr_no_transfer", got_q.size(), 0);

    // Reset in the middle of a third frame
    rx_i = 1'b0;
    step(C);
    rx_i = 1'b1;
    step(2 * C);
    rx_i = 1'b0;
    step(C / 2);
    rx_i  = 1'b1;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", int'(valid_o), 0);
    check("midrst_data", int'(data_o), 0);
    step(2);
    rst_n   = 1'b1;
    ready_i = 1'b1;
    step(500);
    check("midrst_no_bytes", got_q.size(), 0);
    send_frame(8'h7E, C, 1'b1);
    step(300);
    check("midrst_next_nbytes", got_q.size(), 1);
    if (got_q.size() == 1) begin
      rb = got_q[0];
      check("midrst_next_data", int'(rb), 8'h7E);
    end
    check("midrst_ferr", fe_cnt - fe0, 0);
    check("midrst_ovr", ov_cnt - ov0, 1);

    // Random bytes, random stop lengths and gaps: bytes emerge in send order
    got_q.delete();
    exp_q.delete();
    fe0 = fe_cnt; ov0 = ov_cnt;
    for (int r = 0; r < 5; r++) begin
      logic [7:0] d;
      d = 8'($urandom);
      send_frame(d, int'($urandom_range(160, 400)), 1'b1);
      step(int'($urandom_range(0, 300)));
      exp_q.push_back(d);
    end
    step(300);
    check("rand_nbytes", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("rand_byte%0d", i), int'(got_q[i]), int'(exp_q[i]));
    end
    check("rand_ferr", fe_cnt - fe0, 0);
    check("rand_ovr", ov_cnt - ov0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
